// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - command sequencer feeding a 16-bit ALU from a 4-entry register file
//
// Purpose: accepts ALU commands over a valid/ready channel and loads the ALU operand
//   registers from a 4x W register file or an immediate. It captures the ALU result one
//   cycle later, writes it back to the register file, and returns it over a valid/ready
//   response channel.
// Optional feature: define ALU_CTRL_ERR_EN to treat opcodes 9-15 as illegal. Illegal
//   commands suppress write-back and respond with data 0, zero 1 and err 1.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op, cmd_rd, cmd_rs1, cmd_rs2  opcode and register indices
//   cmd_imm_en, cmd_imm               immediate select and value for the B operand
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_zero, rsp_err       captured result, zero flag and illegal-op flag
//   A, B, ALU_Sel                     registered operands and opcode to the ALU
//   ALU_Out, Zero                     combinational result and zero flag from the ALU
//   dbg_sel, dbg_data                 combinational register file read port
module alu_cmd_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_rs1,
  input  logic [1:0]   cmd_rs2,
  input  logic         cmd_imm_en,
  input  logic [W-1:0] cmd_imm,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [3:0]   ALU_Sel,
  input  logic [W-1:0] ALU_Out,
  input  logic         Zero,
  input  logic [1:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic [W-1:0] rf [4];
  logic [1:0]   rd_q;
  logic         illegal_q;

`ifdef ALU_CTRL_ERR_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign illegal_q = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign dbg_data = rf[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      A         <= '0;
      B         <= '0;
      ALU_Sel   <= '0;
      rd_q      <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
`ifdef ALU_CTRL_ERR_EN
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Sources are sampled here, so rd aliasing rs1/rs2 reads the old value.
            A         <= rf[cmd_rs1];
            B         <= cmd_imm_en ? cmd_imm : rf[cmd_rs2];
            ALU_Sel   <= cmd_op;
            rd_q      <= cmd_rd;
            cmd_ready <= 1'b0;
            state     <= EXEC;
`ifdef ALU_CTRL_ERR_EN
            illegal_q <= (cmd_op > 4'd8);
`endif
          end
        end
        EXEC: begin
          rsp_data  <= illegal_q ? '0 : ALU_Out;
          rsp_zero  <= illegal_q ? 1'b1 : Zero;
          rsp_valid <= 1'b1;
          if (!illegal_q) rf[rd_q] <= ALU_Out;
`ifdef ALU_CTRL_ERR_EN
          err_q     <= illegal_q;
`endif
          state     <= RESP;
        end
        RESP: begin
          // cmd_ready only rises after the handshake, so no accept overlaps it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed scoreboard bench for alu_cmd_ctrl with a behavioural ALU
module tb_alu_cmd_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [1:0]   cmd_rd, cmd_rs1, cmd_rs2;
  logic         cmd_imm_en;
  logic [W-1:0] cmd_imm;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_err;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_Sel;
  logic [W-1:0] ALU_Out;
  logic         Zero;
  logic [1:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mrf [4];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_data;
  int           lat;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .Zero(Zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural stand-in for the 16-bit ALU the controller drives.
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      4'd0: ALU_Out = A + B;
      4'd1: ALU_Out = A - B;
      4'd2: ALU_Out = A & B;
      4'd3: ALU_Out = A | B;
      4'd4: ALU_Out = A ^ B;
      4'd5: ALU_Out = ~A;
      4'd6: ALU_Out = (A < B) ? 16'd1 : 16'd0;
      4'd7: ALU_Out = A << 1;
      4'd8: ALU_Out = A >> 1;
      default: ALU_Out = '0;
    endcase
    Zero = (ALU_Out == '0);
  end

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    if (op == 4'd0) r = a + b;
    else if (op == 4'd1) r = a - b;
    else if (op == 4'd2) r = a & b;
    else if (op == 4'd3) r = a | b;
    else if (op == 4'd4) r = a ^ b;
    else if (op == 4'd5) r = ~a;
    else if (op == 4'd6) r = {{(W-1){1'b0}}, (a < b)};
    else if (op == 4'd7) r = {a[W-2:0], 1'b0};
    else if (op == 4'd8) r = {1'b0, a[W-1:1]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic ie, input logic [W-1:0] imm);
    int n;
    exp_t e;
    logic [W-1:0] a, b, r;
    logic illegal;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    a = mrf[rs1];
    b = ie ? imm : mrf[rs2];
    r = ref_alu(op, a, b);
`ifdef ALU_CTRL_ERR_EN
    illegal = (op > 4'd8);
`else
    illegal = 1'b0;
`endif
    if (illegal) begin
      e.data = '0; e.zero = 1'b1; e.err = 1'b1;
    end else begin
      e.data = r; e.zero = (r == '0); e.err = 1'b0;
      mrf[rd] = r;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for the response, optionally holds off rsp_ready for 'hold' cycles, then handshakes.
  task automatic recv(input int hold, output int seen_at);
    exp_t e;
    seen_at = 0;
    while (seen_at < 20) begin
      @(negedge clk);
      seen_at++;
      if (rsp_valid) break;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    if (!rsp_valid) return;
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.data = 'x; e.zero = 1'bx; e.err = 1'bx;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    last_data = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic dbg_check(input string tag, input logic [1:0] sel, input logic [W-1:0] exp);
    dbg_sel = sel;
    #1 check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b0; dbg_sel = '0; last_data = '0;
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_A", {16'd0, A}, 32'd0);
    check("rst_B", {16'd0, B}, 32'd0);
    check("rst_alu_sel", {28'd0, ALU_Sel}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    for (int i = 0; i < 4; i++) dbg_check("rst_rf", 2'(i), 16'h0000);

    // add rd=1 rs1=0 imm=0x000F, with latency check
    send(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 16'h000F);
    check("exec_A", {16'd0, A}, 32'h0000);
    check("exec_B", {16'd0, B}, 32'h000F);
    recv(0, lat);
    check("rsp_latency", lat, 32'd2);
    check("add_result", {16'd0, last_data}, 32'h000F);
    dbg_check("dbg_r1_add", 2'd1, 16'h000F);

    // sub -> zero, then slt
    send(4'd1, 2'd2, 2'd1, 2'd0, 1'b1, 16'h000F);
    recv(0, lat);
    check("sub_result", {16'd0, last_data}, 32'h0000);
    send(4'd6, 2'd3, 2'd2, 2'd1, 1'b0, 16'h0000);
    recv(0, lat);
    check("slt_result", {16'd0, last_data}, 32'h0001);

    // shifts and not with rd == rs1
    send(4'd7, 2'd1, 2'd1, 2'd0, 1'b0, 16'h0000);
    recv(0, lat);
    check("shl_result", {16'd0, last_data}, 32'h001E);
    send(4'd8, 2'd1, 2'd1, 2'd0, 1'b0, 16'h0000);
    recv(0, lat);
    check("shr_result", {16'd0, last_data}, 32'h000F);
    send(4'd5, 2'd0, 2'd1, 2'd0, 1'b0, 16'h0000);
    recv(0, lat);
    check("not_result", {16'd0, last_data}, 32'hFFF0);
    dbg_check("dbg_r0_not", 2'd0, 16'hFFF0);

    // xor with 5 cycles of backpressure and a pending command
    send(4'd4, 2'd2, 2'd1, 2'd3, 1'b0, 16'h0000);
    @(negedge clk);
    cmd_op = 4'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd2; cmd_rs2 = 2'd3; cmd_imm_en = 1'b0;
    cmd_valid = 1'b1;
    recv(5, lat);
    check("xor_result", {16'd0, last_data}, 32'h000E);
    check("no_accept_at_hs_sel", {28'd0, ALU_Sel}, 32'd4);
    check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    send(4'd0, 2'd0, 2'd2, 2'd3, 1'b0, 16'h0000);
    check("pending_alu_sel", {28'd0, ALU_Sel}, 32'd0);
    recv(0, lat);
    check("pending_add_result", {16'd0, last_data}, 32'h000F);

    // opcode outside the ALU's set
    send(4'hA, 2'd1, 2'd1, 2'd0, 1'b0, 16'h0000);
    recv(0, lat);
`ifdef ALU_CTRL_ERR_EN
    dbg_check("illegal_r1_kept", 2'd1, 16'h000F);
`else
    dbg_check("illegal_r1_zeroed", 2'd1, 16'h0000);
`endif

    // reset during EXEC drops the command
    send(4'd0, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0005);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    dbg_check("mid_rst_r2", 2'd2, 16'h0000);
    sb.delete();
    for (int i = 0; i < 4; i++) mrf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_A", {16'd0, A}, 32'd0);
    check("post_rst_B", {16'd0, B}, 32'd0);
    check("post_rst_sel", {28'd0, ALU_Sel}, 32'd0);
    check("post_rst_data", {16'd0, rsp_data}, 32'd0);
    check("post_rst_zero", {31'd0, rsp_zero}, 32'd0);
    check("post_rst_err", {31'd0, rsp_err}, 32'd0);
    dbg_check("post_rst_r0", 2'd0, 16'h0000);

    // normal operation resumes
    send(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0003);
    recv(0, lat);
    check("post_rst_add", {16'd0, last_data}, 32'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
